uart_tx_arbiter: RTL

- Shares one uart_tx serializer between NUM_REQ byte-stream requesters, e.g. price/order reporters in the arbitrage engine.
- Grants one requester at a time in round-robin order. A grant holds for a whole packet, delimited by s_last, so bytes from different packets never interleave on the line.
- Sequences the serializer's en/busy handshake so each byte is issued exactly once.
- A starvation timeout releases a grant whose owner stalls mid-packet.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 13 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx.sv | 55 +++++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_pkg;

  localparam int PAYLOAD_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte stream bundle: one valid/data/last/ready lane per requester.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
);
  logic [NUM_REQ-1:0]              s_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] s_data;
  logic [NUM_REQ-1:0]              s_last;
  logic [NUM_REQ-1:0]              s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set bit of req at or after ptr, wrapping.
module rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      index
);

  // Walk from farthest to nearest so the candidate closest to ptr is written last and wins.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte serializer: start bit, PAYLOAD_BITS data bits LSB first, one stop bit.
// Busy rises the cycle after an accepted en and falls after the stop bit.
module uart_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 5_000_000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(PAYLOAD_BITS + 2);

  logic [CW-1:0]         bit_tmr;
  logic [BW-1:0]         bits_left;
  logic [PAYLOAD_BITS:0] shreg;

  // Bit timer is a down-counter; each terminal count shifts out the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      bit_tmr      <= '0;
      bits_left    <= '0;
      shreg        <= '1;
    end else if (!uart_tx_busy) begin
      uart_txd <= 1'b1;
      if (uart_tx_en) begin
        uart_tx_busy <= 1'b1;
        uart_txd     <= 1'b0;
        shreg        <= {1'b1, uart_tx_data};
        bits_left    <= BW'(PAYLOAD_BITS + 1);
        bit_tmr      <= CW'(CPB - 1);
      end
    end else if (bit_tmr == '0) begin
      if (bits_left == '0) begin
        uart_tx_busy <= 1'b0;
      end else begin
        uart_txd  <= shreg[0];
        shreg     <= {1'b1, shreg[PAYLOAD_BITS:1]};
        bits_left <= bits_left - 1'b1;
        bit_tmr   <= CW'(CPB - 1);
      end
    end else begin
      bit_tmr <= bit_tmr - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one uart_tx serializer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ARB       | no owner; pick next valid requester starting at rr_ptr
// REQ       | owner granted; waiting for its next byte, timeout counter runs
// WAIT_BUSY | byte issued (tx_en pulse); waiting for serializer busy to rise
// WAIT_DONE | serializer sending; on busy fall end packet or fetch next byte
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int IW             = idx_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_tx_arbiter_if.slave        s_if,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_id,
  output logic                    timeout_pulse
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t              state;
  logic [IW-1:0]           rr_ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    last_r;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic                    own_valid;
  logic                    own_last;
  logic [PAYLOAD_BITS-1:0] own_data;
  logic                    handshake;
  logic [IW-1:0]           next_ptr;
  logic [NUM_REQ-1:0]      ready_vec;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (s_if.s_valid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign own_valid = s_if.s_valid[grant_id];
  assign own_last  = s_if.s_last[grant_id];
  assign own_data  = s_if.s_data[int'(grant_id) * PAYLOAD_BITS +: PAYLOAD_BITS];
  assign handshake = (state == REQ) && own_valid && !tx_busy;
  // The owner that just finished or timed out drops to lowest priority.
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Only the owner's ready bit can ever be set, so s_ready is one-hot or zero.
  always_comb begin
    ready_vec           = '0;
    ready_vec[grant_id] = handshake;
  end

  assign s_if.s_ready = ready_vec;

  // Arbiter FSM, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      rr_ptr        <= '0;
      cnt           <= '0;
      last_r        <= 1'b0;
      tx_en         <= 1'b0;
      tx_data       <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      tx_en         <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ARB: begin
          if (pick_valid) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (handshake) begin
            tx_data <= own_data;
            last_r  <= own_last;
            tx_en   <= 1'b1;
            cnt     <= '0;
            state   <= WAIT_BUSY;
          end else if (cnt == CNT_LAST) begin
            // Stalled owner: abandon the partial packet without issuing anything.
            timeout_pulse <= 1'b1;
            grant_valid   <= 1'b0;
            rr_ptr        <= next_ptr;
            cnt           <= '0;
            state         <= ARB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          // Busy lags en by a cycle; holding here keeps the byte from being issued twice.
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_r) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= ARB;
            end else begin
              cnt   <= '0;
              state <= REQ;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
